// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flag_pkg
// Brief    : ALU opcode encodings and flag bit positions for the flag bus.
// Revision : 1.0
// ============================================================================
package flag_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_CMP = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_MOV = 4'b0110,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010
    } alu_op_e;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : flag_pkg
`default_nettype wire

// File: rtl/flag_unit_calc.sv
`default_nettype none
// ============================================================================
// Module   : flag_calc
// Brief    : Combinational {S,Z,C,V} derivation from one ALU operation.
// Revision : 1.0
// ============================================================================
module flag_calc
    import flag_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] result_i,
    output logic [3:0]       flags_o
);

    localparam int N = WIDTH - 1;

    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] sll_w;
    logic [WIDTH:0] srl_w;
    logic [3:0]     k_w;

    assign k_w   = b_i[3:0];
    assign sum_w = {1'b0, a_i} + {1'b0, b_i};
    // Guard bit catches the last bit shifted out; k=0 naturally yields 0.
    assign sll_w = {1'b0, a_i} << k_w;
    assign srl_w = {a_i, 1'b0} >> k_w;

    always_comb begin
        flags_o         = 4'b0000;
        flags_o[FLAG_S] = result_i[N];
        flags_o[FLAG_Z] = (result_i == '0);
        case (op_i)
            OP_ADD: begin
                flags_o[FLAG_C] = sum_w[WIDTH];
                flags_o[FLAG_V] = (a_i[N] == b_i[N]) & (result_i[N] != a_i[N]);
            end
            OP_SUB, OP_CMP: begin
                flags_o[FLAG_C] = (a_i < b_i);
                flags_o[FLAG_V] = (a_i[N] != b_i[N]) & (result_i[N] != a_i[N]);
            end
            OP_AND, OP_OR, OP_XOR, OP_MOV: ;
            OP_SLL: flags_o[FLAG_C] = sll_w[WIDTH];
            OP_SRL, OP_SRA: flags_o[FLAG_C] = srl_w[0];
            default: flags_o = 4'b0000;
        endcase
    end

endmodule : flag_calc
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_unit
// Brief    : Two-stage flag update pipeline and architectural flag register.
// Revision : 1.0
// ============================================================================
module flag_unit
    import flag_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid_i,
    input  logic             flag_we_i,
    input  logic [3:0]       alu_op_i,
    input  logic [WIDTH-1:0] alu_a_i,
    input  logic [WIDTH-1:0] alu_b_i,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [3:0]       flag_out_o,
    output logic             flag_pending_o
);

    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [WIDTH-1:0] s1_r_q, s1_r_d;
    logic             s2_valid_q, s2_valid_d;
    logic [3:0]       flag_q, flag_d;
    logic [3:0]       calc_flags_w;
    logic             capture_w;
    logic             advance_w;

    flag_calc #(.WIDTH(WIDTH)) u_calc (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_i (s1_r_q),
        .flags_o  (calc_flags_w)
    );

    assign capture_w = alu_valid_i & flag_we_i;
    assign advance_w = s1_valid_q & ~flush_i;

    // The stage-2 flag register doubles as the architectural register, so an
    // op accepted in cycle N is on flag_out in N+2; s2_valid keeps the write
    // visible as pending for the cycle in which it becomes committed.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_r_d     = s1_r_q;
        s2_valid_d = s2_valid_q;
        flag_d     = flag_q;
        if (!stall_i) begin
            s1_valid_d = capture_w & ~flush_i;
            if (capture_w) begin
                s1_op_d = alu_op_i;
                s1_a_d  = alu_a_i;
                s1_b_d  = alu_b_i;
                s1_r_d  = alu_result_i;
            end
            s2_valid_d = advance_w;
            if (advance_w) begin
                flag_d = calc_flags_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            flag_q     <= 4'b0000;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            flag_q     <= flag_d;
        end
        s1_op_q <= s1_op_d;
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
        s1_r_q  <= s1_r_d;
    end

    assign flag_out_o     = flag_q;
    assign flag_pending_o = s1_valid_q | s2_valid_q;

endmodule : flag_unit
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_unit
// Brief    : Directed and random self-checking bench for flag_unit.
// Revision : 1.0
// ============================================================================
module tb_flag_unit;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, flag_we, stall, flush;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [3:0]       flag_out;
    logic             flag_pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flag_unit #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid_i    (alu_valid),
        .flag_we_i      (flag_we),
        .alu_op_i       (alu_op),
        .alu_a_i        (alu_a),
        .alu_b_i        (alu_b),
        .alu_result_i   (alu_result),
        .stall_i        (stall),
        .flush_i        (flush),
        .flag_out_o     (flag_out),
        .flag_pending_o (flag_pending)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU, used only to supply a consistent alu_result.
    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return b;
            4'd8:    return a << b[3:0];
            4'd9:    return a >> b[3:0];
            4'd10:   return 16'($signed(a) >>> b[3:0]);
            default: return 16'($urandom);
        endcase
    endfunction

    // Flags from integer arithmetic: carry/borrow by magnitude, overflow by range.
    function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] r);
        int ua, ub, sa, sb, k;
        bit s, z, c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        k  = int'(b[3:0]);
        s = r[15]; z = (r == 16'h0); c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                c = (ua + ub) > 65535;
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            4'd1, 4'd2: begin
                c = ua < ub;
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            4'd3, 4'd4, 4'd5, 4'd6: ;
            4'd8:        c = (k != 0) && ((((ua << k) >> 16) & 1) != 0);
            4'd9, 4'd10: c = (k != 0) && (((ua >> (k - 1)) & 1) != 0);
            default: begin s = 1'b0; z = 1'b0; end
        endcase
        return {s, z, c, v};
    endfunction

    typedef struct {
        logic [3:0] f;
        int         age;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_flags;

    // Each accepted write lives for two cycles of forward progress; it becomes
    // architectural on its first step unless flushed while still young.
    task automatic model_edge();
        ent_t nq[$];
        if (rst) begin
            q.delete();
            m_flags = 4'b0000;
            return;
        end
        if (stall) return;
        foreach (q[i]) begin
            if (q[i].age == 1 && !flush) begin
                m_flags = q[i].f;
                nq.push_back('{q[i].f, 2});
            end
        end
        if (alu_valid && flag_we && !flush)
            nq.push_back('{ref_flags(alu_op, alu_a, alu_b, alu_result), 1});
        q = nq;
    endtask

    task automatic cyc(input logic v, input logic we, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic st, input logic fl, input logic rs);
        alu_valid = v; flag_we = we; alu_op = op; alu_a = a; alu_b = b;
        alu_result = ref_alu(op, a, b);
        stall = st; flush = fl; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("model_flag_out", 32'(flag_out), 32'(m_flags));
        check_eq("model_pending", 32'(flag_pending), 32'(q.size() != 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
    endtask

    task automatic op(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
        cyc(1, 1, opc, a, b, 0, 0, 0);
    endtask

    initial begin
        m_flags = 4'b0000;
        cyc(0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        cyc(1, 1, 4'd0, 16'hFFFF, 16'h1, 1, 1, 1);
        check_eq("reset_flags", 32'(flag_out), 32'h0);
        check_eq("reset_pending", 32'(flag_pending), 32'h0);

        op(4'd0, 16'h7FFF, 16'h0001);
        check_eq("add_pend_n1", 32'(flag_pending), 32'h1);
        idle(1);
        check_eq("add_pend_n2", 32'(flag_pending), 32'h1);
        check_eq("add_flags_n2", 32'(flag_out), 32'h9);
        idle(1);
        check_eq("add_pend_n3", 32'(flag_pending), 32'h0);

        op(4'd1, 16'h0003, 16'h0005); idle(2);
        check_eq("sub_flags", 32'(flag_out), 32'hA);

        op(4'd2, 16'h0005, 16'h0005); idle(2);
        check_eq("cmp_flags", 32'(flag_out), 32'h4);

        op(4'd0, 16'hFFFF, 16'h0001);
        cyc(1, 0, 4'd5, 16'h1234, 16'h1234, 0, 0, 0);
        idle(3);
        check_eq("add_carry_xor_nowe", 32'(flag_out), 32'h6);

        op(4'd8, 16'h8001, 16'h0001); idle(2);
        check_eq("sll_flags", 32'(flag_out), 32'h2);

        op(4'd0, 16'h7FFF, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 4'd0, 16'h0, 16'h0, 1, 0, 0);
            check_eq("stall_pending", 32'(flag_pending), 32'h1);
            check_eq("stall_flags_held", 32'(flag_out), 32'h2);
        end
        idle(1);
        check_eq("stall_commit", 32'(flag_out), 32'h9);
        idle(2);

        op(4'd0, 16'hFFFF, 16'h0001);
        cyc(0, 0, 4'd0, 16'h0, 16'h0, 0, 1, 0);
        check_eq("flush_flags", 32'(flag_out), 32'h9);
        check_eq("flush_pending", 32'(flag_pending), 32'h0);
        idle(2);
        check_eq("flush_no_late", 32'(flag_out), 32'h9);

        op(4'd1, 16'h0003, 16'h0005);
        cyc(0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        check_eq("rst_mid_flags", 32'(flag_out), 32'h0);
        check_eq("rst_mid_pending", 32'(flag_pending), 32'h0);
        idle(2);
        check_eq("rst_no_late", 32'(flag_out), 32'h0);

        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                4'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flag_unit
`default_nettype wire

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the 4-bit status flag bus {S,Z,C,V} that the branch-condition logic consumes.
- Derives sign, zero, carry and overflow from each ALU operation, pipelines the update over two stages, and holds the architectural flag register.
- Exports a pending indicator so the control unit can delay a conditional jump until the flags it depends on have been committed.
- Sits between the ALU output and the jump condition evaluator.

Parameters:
- WIDTH, 16, datapath width of ALU operands and result.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU operation present this cycle.
- flag_we  in  1  operation updates flags; ignored unless alu_valid=1.
- alu_op  in  4  operation code; encodings in the shared package.
- alu_a  in  WIDTH  operand A.
- alu_b  in  WIDTH  operand B. For shifts, bits [3:0] are the shift amount.
- alu_result  in  WIDTH  ALU result for this operation.
- stall  in  1  freezes both pipeline stages and the flag register.
- flush  in  1  kills the stage-1 entry. Does not affect stage 2.
- flag_out  out  4  committed flags {S,Z,C,V}.
- flag_pending  out  1  a flag write is in stage 1 or stage 2.

Behaviour:
- Reset: stage-1 valid=0, stage-2 valid=0, flag_out=4'b0000, flag_pending=0. Reset has priority over stall and flush, and discards any in-flight update.
- Stage 1, capture:
  - If alu_valid & flag_we & !stall, register alu_op, alu_a, alu_b and alu_result, and set s1_valid.
  - Otherwise, when !stall, clear s1_valid.
  - flush (with !stall) clears s1_valid and wins over a simultaneous capture.
- Stage 2, compute:
  - When !stall, s2_valid<=s1_valid (after flush) and the computed flags are registered.
- Commit:
  - When s2_valid & !stall, flag_out <= computed flags.
  - Latency: flags from an op accepted in cycle N are visible on flag_out in cycle N+2.
  - Operations with flag_we=0 never disturb flag_out.
- flag_pending = s1_valid | s2_valid. Purely registered, with no combinational path from the inputs.
- Stall freezes every register, including a pending commit. Back-to-back writes commit in order, one per cycle.
- Flag rules (r = result, n = WIDTH-1):
  - S = r[n].
  - Z = (r == 0).
- ADD:
  - C = bit WIDTH of the (WIDTH+1)-bit sum a+b, computed internally.
  - V = (a[n]==b[n]) & (r[n]!=a[n]).
- SUB and CMP:
  - C = borrow, i.e. 1 iff a<b unsigned.
  - V = (a[n]!=b[n]) & (r[n]!=a[n]).
  - CMP uses the same flag rules. Its result is supplied by the ALU as a-b.
- AND, OR, XOR, MOV: C=0, V=0.
- Shift amount k = b[3:0].
  - SLL: C = a[WIDTH-k] (last bit shifted out).
  - SRL and SRA: C = a[k-1].
  - k=0: C=0.
  - All shifts: V=0.
- Undefined opcodes: flags = 4'b0000, but the write still commits.

Decomposition:
- Package flag_pkg holds:
  - the alu_op encodings (ADD 0000, SUB 0001, CMP 0010, AND 0011, OR 0100, XOR 0101, MOV 0110, SLL 1000, SRL 1001, SRA 1010);
  - the flag bit indices (S=3, Z=2, C=1, V=0).
- One natural sub-module, flag_calc: purely combinational (op, a, b, result) -> 4-bit flags, instantiated between stage 1 and stage 2.

Test Plan (WIDTH=16):
- ADD a=0x7FFF, b=0x0001, r=0x8000, flag_we=1 in cycle N:
  - flag_pending=1 in N+1 and N+2.
  - flag_out=4'b1001 from N+2; flag_pending=0 in N+3.
- SUB a=0x0003, b=0x0005, r=0xFFFE -> flag_out=4'b1010.
- CMP a=0x0005, b=0x0005, r=0x0000 -> flag_out=4'b0100.
- ADD 0xFFFF+0x0001, r=0x0000, then the next cycle XOR with r=0x0000 and flag_we=0:
  - flag_out=4'b0110 and stays there.
- SLL a=0x8001, b=1, r=0x0002 -> flag_out=4'b0010.
- Stall and flush on ADD 0x7FFF+0x0001:
  - stall held for 3 cycles after capture: commit delayed by exactly 3 cycles, flag_pending held high throughout.
  - flush in the cycle after capture: flag_out unchanged and flag_pending drops.
- Reset mid-operation: issue SUB, assert rst the next cycle -> flag_out=0000 and flag_pending=0, with no late commit.
